serial_subtractor: RTL
======================

# serial_subtractor

Multi-cycle unsigned N-bit subtractor that computes `a - b` one bit per clock, LSB first, with a registered borrow chain. It sits directly downstream of the single-bit subtractor cells: it consumes one bit-level difference/borrow per cycle and assembles the full word result. Operands enter through a valid/ready handshake. The result leaves through a second valid/ready handshake, so the block drops into datapaths that cannot afford a WIDTH-bit ripple path.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 2 or more.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_valid`  in  1  operands on `a`/`b` are valid.
- `start_ready`  out  1  block is able to accept operands.
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `diff`  out  WIDTH  result `a - b` mod 2^WIDTH, or saturated (see Configuration).
- `borrow_out`  out  1  final borrow; 1 means `a < b`.
- `result_valid`  out  1  `diff`/`borrow_out` are valid.
- `result_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in RUN state.

## Operation
- FSM has three states:
  - IDLE: `start_ready=1`.
  - RUN: bit-serial computation.
  - DONE: `result_valid=1`.
- Accept: on an edge where the state is IDLE and `start_valid=1`:
  - latch `a`/`b` into shift registers;
  - clear the borrow FF to 0 and the bit counter to 0;
  - go to RUN.
- RUN, each edge:
  - bit cell computes `d = ai ^ bi ^ bin` and `bout = (~ai & bi) | (~(ai ^ bi) & bin)`, where `ai`/`bi` are the current LSBs and `bin` is the borrow FF;
  - `d` shifts into the MSB of the result register (right shift);
  - borrow FF is set to `bout`;
  - counter increments.
- RUN exit: when the counter equals WIDTH-1 on an edge, that edge processes the last bit and moves the FSM to DONE.
- DONE: `diff` and `borrow_out` are held stable until an edge with `result_ready=1`, then the FSM returns to IDLE.
- `start_valid` is ignored in RUN and DONE. Operands must be re-presented once back in IDLE.
- No pipelining: there is at most one operation in flight.
- Reset at any time, including mid-RUN or in DONE, aborts the operation immediately. The result is discarded.

## Timing
- Reset values:
  - state is IDLE;
  - `start_ready=1`, `result_valid=0`, `busy=0`;
  - `diff=0`, `borrow_out=0`;
  - shift registers, counter and borrow FF are all 0.
- Latency: `result_valid` rises exactly WIDTH cycles after the accept edge, i.e. after WIDTH rising edges in RUN.
- Throughput: with `result_ready` tied high, one result every WIDTH+2 cycles (accept, WIDTH RUN edges, release edge, then IDLE).
- `start_ready` falls in the cycle after the accept edge. It rises in the cycle after the release edge.
- `diff` and `borrow_out` only change in RUN. Mid-computation values are not meaningful while `result_valid=0`.
- Backpressure: the DONE state has no timeout. The outputs stay frozen for any number of cycles with `result_ready=0`.
- `result_ready` high in IDLE or RUN has no effect.

## Configuration
- Macro `SERIAL_SUBTRACTOR_SAT_EN`.
- Defined: on the edge entering DONE, if the final borrow is 1, `diff` is forced to 0 (unsigned saturation at zero). `borrow_out` still reports 1.
- Undefined: `diff` is the wrapped two's-complement result mod 2^WIDTH. The saturation logic is not generated.

## Structure
- Package `serial_sub_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_RUN`, `ST_DONE`);
  - default WIDTH constant;
  - counter width function `$clog2(WIDTH)`.
- Sub-module `serial_sub_bit`: purely combinational full-subtractor bit cell (`ai`, `bi`, `bin` → `d`, `bout`). It is instantiated once. FSM, counter, shift registers and borrow FF stay in the top module.

## Test plan
- WIDTH=8, a=0x5A, b=0x23, `result_ready=1` → `result_valid` 8 cycles after accept, `diff=0x37`, `borrow_out=0`.
- a=0x10, b=0x20 → `borrow_out=1`. `diff=0xF0` without the macro; `diff=0x00` with `SERIAL_SUBTRACTOR_SAT_EN`.
- a=0xFF, b=0xFF, then a=0x00, b=0x00 → `diff=0x00` and `borrow_out=0` for both. a=0x00, b=0x01 → 0xFF with borrow 1 (unsaturated).
- Hold `result_ready=0` for 5 cycles in DONE → `diff`/`result_valid` stable, `start_ready=0`. Raise `result_ready` → `start_ready=1` the next cycle.
- Pulse `start_valid` with new operands during RUN → ignored; the result matches the first operands.
- Assert `rst` after 3 RUN edges → all outputs at reset values in the same cycle. A new operation afterwards produces the correct result.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width; a 1-bit counter is the floor for the smallest legal WIDTH.
    function automatic int cnt_width(input int width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand and result handshakes of serial_subtractor bundled as one interface.
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             result_valid;
    logic             result_ready;
    logic             busy;

    // Producer/consumer side.
    modport master (
        output start_valid, a, b, result_ready,
        input  start_ready, diff, borrow_out, result_valid, busy
    );

    // Subtractor side.
    modport slave (
        input  start_valid, a, b, result_ready,
        output start_ready, diff, borrow_out, result_valid, busy
    );
endinterface

// File: rtl/serial_sub_bit.sv
// Combinational full-subtractor cell: one difference bit and its borrow.
module serial_sub_bit (
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = ai ^ bi ^ bin;
    assign bout = (~ai & bi) | (~(ai ^ bi) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Optional `SERIAL_SUBTRACTOR_SAT_EN: clamp diff to zero when the final borrow is set.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic               clk,
    input logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             borrow_out_q;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last_bit;
    logic             start_ready;
    logic             result_valid;
    logic             busy;
    logic             bit_d;
    logic             bit_bout;

    serial_sub_bit u_bit (
        .ai   (a_sh[0]),
        .bi   (b_sh[0]),
        .bin  (borrow_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign last_bit = (state == ST_RUN) && (cnt == LAST);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b0;
        case (state)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (bus.start_valid) begin
                    accept   = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                result_valid = 1'b1;
                if (bus.result_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Result and final borrow only move in RUN, so they stay frozen through DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh         <= '0;
            b_sh         <= '0;
            diff_q       <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            cnt          <= '0;
        end else if (accept) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            borrow_q <= 1'b0;
            cnt      <= '0;
        end else if (state == ST_RUN) begin
            a_sh         <= a_sh >> 1;
            b_sh         <= b_sh >> 1;
            borrow_q     <= bit_bout;
            borrow_out_q <= bit_bout;
            cnt          <= cnt + CW'(1);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
            if (last_bit && bit_bout) begin
                diff_q <= '0;
            end else begin
                diff_q <= {bit_d, diff_q[WIDTH-1:1]};
            end
`else
            diff_q <= {bit_d, diff_q[WIDTH-1:1]};
`endif
        end
    end

    assign bus.start_ready  = start_ready;
    assign bus.result_valid = result_valid;
    assign bus.busy         = busy;
    assign bus.diff         = diff_q;
    assign bus.borrow_out   = borrow_out_q;

endmodule
